// File: rtl/formula_sched_pkg.sv
// Shared types and helpers for the formula scheduler: slot state encoding and
// modulo pointer arithmetic.
`default_nettype none

package formula_sched_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } slot_state_t;

  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/formula_1_impl_1_top.sv
// Formula 1 worker, parallel flavour: isqrt(a) + isqrt(b) + isqrt(c) using
// three concurrent root units; result registered, latency 17 cycles.
`default_nettype none

module formula_1_impl_1_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        res_vld,
  output logic [31:0] res
);

  logic        done_a, done_b, done_c;
  logic [15:0] y_a, y_b, y_c;
  logic        res_vld_q;
  logic [31:0] res_q;

  isqrt u_sqrt_a (.clk(clk), .rst(rst), .start_i(arg_vld), .x_i(a), .done_o(done_a), .y_o(y_a));
  isqrt u_sqrt_b (.clk(clk), .rst(rst), .start_i(arg_vld), .x_i(b), .done_o(done_b), .y_o(y_b));
  isqrt u_sqrt_c (.clk(clk), .rst(rst), .start_i(arg_vld), .x_i(c), .done_o(done_c), .y_o(y_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      res_vld_q <= done_a & done_b & done_c;
      if (done_a & done_b & done_c)
        res_q <= {16'd0, y_a} + {16'd0, y_b} + {16'd0, y_c};
    end
  end

  assign res_vld = res_vld_q;
  assign res     = res_q;

endmodule

`default_nettype wire

// File: rtl/formula_1_impl_2_top.sv
// Formula 1 worker, shared flavour: one root unit reused for a, b, c in turn;
// result registered, latency 51 cycles.
`default_nettype none

module formula_1_impl_2_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        res_vld,
  output logic [31:0] res
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_A = 2'd1, W_B = 2'd2, W_C = 2'd3} wstate_t;

  wstate_t     st_q;
  logic [31:0] b_q, c_q, acc_q, res_q;
  logic        res_vld_q;
  logic        sq_start, sq_done;
  logic [31:0] sq_x;
  logic [15:0] sq_y;

  assign sq_start = ((st_q == W_IDLE) && arg_vld) ||
                    (sq_done && ((st_q == W_A) || (st_q == W_B)));
  assign sq_x     = (st_q == W_IDLE) ? a : (st_q == W_A) ? b_q : c_q;

  isqrt u_sqrt (.clk(clk), .rst(rst), .start_i(sq_start), .x_i(sq_x), .done_o(sq_done), .y_o(sq_y));

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= W_IDLE;
      b_q       <= '0;
      c_q       <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      case (st_q)
        W_IDLE: if (arg_vld) begin
          b_q  <= b;
          c_q  <= c;
          st_q <= W_A;
        end
        W_A: if (sq_done) begin
          acc_q <= {16'd0, sq_y};
          st_q  <= W_B;
        end
        W_B: if (sq_done) begin
          acc_q <= acc_q + {16'd0, sq_y};
          st_q  <= W_C;
        end
        default: if (sq_done) begin
          res_q     <= acc_q + {16'd0, sq_y};
          res_vld_q <= 1'b1;
          st_q      <= W_IDLE;
        end
      endcase
    end
  end

  assign res_vld = res_vld_q;
  assign res     = res_q;

endmodule

`default_nettype wire

// File: rtl/formula_2_top.sv
// Formula 2 worker: isqrt(a + isqrt(b + isqrt(c))) with one chained root unit;
// result registered, latency 51 cycles.
`default_nettype none

module formula_2_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        res_vld,
  output logic [31:0] res
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_C = 2'd1, W_B = 2'd2, W_A = 2'd3} wstate_t;

  wstate_t     st_q;
  logic [31:0] a_q, b_q, res_q;
  logic        res_vld_q;
  logic        sq_start, sq_done;
  logic [31:0] sq_x;
  logic [15:0] sq_y;

  assign sq_start = ((st_q == W_IDLE) && arg_vld) ||
                    (sq_done && ((st_q == W_C) || (st_q == W_B)));
  assign sq_x     = (st_q == W_IDLE) ? c :
                    (st_q == W_C)    ? (b_q + {16'd0, sq_y}) :
                                       (a_q + {16'd0, sq_y});

  isqrt u_sqrt (.clk(clk), .rst(rst), .start_i(sq_start), .x_i(sq_x), .done_o(sq_done), .y_o(sq_y));

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= W_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      case (st_q)
        W_IDLE: if (arg_vld) begin
          a_q  <= a;
          b_q  <= b;
          st_q <= W_C;
        end
        W_C: if (sq_done) st_q <= W_B;
        W_B: if (sq_done) st_q <= W_A;
        default: if (sq_done) begin
          res_q     <= {16'd0, sq_y};
          res_vld_q <= 1'b1;
          st_q      <= W_IDLE;
        end
      endcase
    end
  end

  assign res_vld = res_vld_q;
  assign res     = res_q;

endmodule

`default_nettype wire

// File: rtl/formula_sched_slot.sv
// One scheduler slot: IDLE/RUN/DONE state, captured result, sticky error and
// the worker selected by FORMULA/IMPL.
`default_nettype none

module formula_sched_slot
  import formula_sched_pkg::*;
#(
  parameter int FORMULA = 1,
  parameter int IMPL    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        consume_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  output logic        idle_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] res_o
);

  slot_state_t st_q;
  logic [31:0] res_q;
  logic        err_q;
  logic        wrk_vld;
  logic [31:0] wrk_res;

  generate
    if (FORMULA == 2) begin : g_f2
      formula_2_top u_worker (
        .clk(clk), .rst(rst), .arg_vld(start_i), .a(a_i), .b(b_i), .c(c_i),
        .res_vld(wrk_vld), .res(wrk_res));
    end else if (IMPL == 2) begin : g_f1_impl2
      formula_1_impl_2_top u_worker (
        .clk(clk), .rst(rst), .arg_vld(start_i), .a(a_i), .b(b_i), .c(c_i),
        .res_vld(wrk_vld), .res(wrk_res));
    end else begin : g_f1_impl1
      formula_1_impl_1_top u_worker (
        .clk(clk), .rst(rst), .arg_vld(start_i), .a(a_i), .b(b_i), .c(c_i),
        .res_vld(wrk_vld), .res(wrk_res));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE:    if (start_i) st_q <= RUN;
        RUN:     if (wrk_vld) begin
          res_q <= wrk_res;
          st_q  <= DONE;
        end
        DONE:    if (consume_i) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
      // A worker result outside RUN means the slot bookkeeping is broken.
      if (wrk_vld && (st_q != RUN)) err_q <= 1'b1;
    end
  end

  assign idle_o = (st_q == IDLE);
  assign done_o = (st_q == DONE);
  assign err_o  = err_q;
  assign res_o  = res_q;

endmodule

`default_nettype wire

// File: rtl/isqrt.sv
// Sequential 32-bit integer square root, one result bit per cycle.
// done_o pulses 16 cycles after start_i; y_o holds the root until the next start.
`default_nettype none

module isqrt (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] x_i,
  output logic        done_o,
  output logic [15:0] y_o
);

  logic [31:0] x_q;
  logic [31:0] rem_q;
  logic [15:0] root_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  logic [33:0] rem_sh;
  logic [31:0] trial;
  logic        fits;

  // Remainder never exceeds 2*root+1, so 32 bits of it are plenty.
  assign rem_sh = {rem_q, x_q[31:30]};
  assign trial  = {14'd0, root_q, 2'b01};
  assign fits   = (rem_sh >= {2'b00, trial});

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        x_q    <= x_i;
        rem_q  <= '0;
        root_q <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        x_q    <= {x_q[29:0], 2'b00};
        rem_q  <= fits ? (rem_sh[31:0] - trial) : rem_sh[31:0];
        root_q <= {root_q[14:0], fits};
        cnt_q  <= cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign y_o    = root_q;

endmodule

`default_nettype wire

// File: rtl/formula_sched.sv
// Round-robin scheduler over N_WORKERS formula workers with in-order result
// return and valid/ready backpressure on both sides.
`default_nettype none

module formula_sched
  import formula_sched_pkg::*;
#(
  parameter int FORMULA   = 1,
  parameter int IMPL      = 1,
  parameter int N_WORKERS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arg_vld,
  output logic                             arg_rdy,
  input  logic [31:0]                      a,
  input  logic [31:0]                      b,
  input  logic [31:0]                      c,
  output logic                             res_vld,
  input  logic                             res_rdy,
  output logic [31:0]                      res,
  output logic [$clog2(N_WORKERS+1)-1:0]   inflight,
  output logic                             err
);

  localparam int PTR_W = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
  localparam int CNT_W = $clog2(N_WORKERS + 1);

  logic [PTR_W-1:0]     in_ptr_q, out_ptr_q;
  logic [N_WORKERS-1:0] slot_idle, slot_done, slot_err, slot_start, slot_consume;
  logic [31:0]          slot_res [N_WORKERS];
  logic                 accept, consume;
  logic [CNT_W-1:0]     busy_cnt;

  assign arg_rdy = slot_idle[in_ptr_q];
  assign res_vld = slot_done[out_ptr_q];
  assign res     = slot_res[out_ptr_q];
  assign accept  = arg_vld && arg_rdy;
  assign consume = res_vld && res_rdy;

  generate
    for (genvar k = 0; k < N_WORKERS; k++) begin : g_slot
      assign slot_start[k]   = accept  && (in_ptr_q  == PTR_W'(k));
      assign slot_consume[k] = consume && (out_ptr_q == PTR_W'(k));

      formula_sched_slot #(.FORMULA(FORMULA), .IMPL(IMPL)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .start_i   (slot_start[k]),
        .consume_i (slot_consume[k]),
        .a_i       (a),
        .b_i       (b),
        .c_i       (c),
        .idle_o    (slot_idle[k]),
        .done_o    (slot_done[k]),
        .err_o     (slot_err[k]),
        .res_o     (slot_res[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
    end else begin
      if (accept)  in_ptr_q  <= PTR_W'(ptr_inc(32'(in_ptr_q),  N_WORKERS));
      if (consume) out_ptr_q <= PTR_W'(ptr_inc(32'(out_ptr_q), N_WORKERS));
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int k = 0; k < N_WORKERS; k++)
      busy_cnt = busy_cnt + CNT_W'(!slot_idle[k]);
  end

  assign inflight = busy_cnt;
  assign err      = |slot_err;

endmodule

`default_nettype wire

// File: tb/tb_formula_sched.sv
// Directed bench for formula_sched: one FORMULA=2 scheduler for the main
// scenarios plus two small FORMULA=1 schedulers for single-transaction latency.
`default_nettype none

module tb_formula_sched;

  logic        clk;
  logic        rst;
  logic [31:0] a, b, c;

  logic        arg_vld, arg_rdy, res_vld, res_rdy, err;
  logic [31:0] res;
  logic [2:0]  inflight;

  logic        f1_vld, f1_rdy;
  logic        f1a_arg_rdy, f1a_res_vld, f1a_err;
  logic        f1b_arg_rdy, f1b_res_vld, f1b_err;
  logic [31:0] f1a_res, f1b_res;
  logic [1:0]  f1a_inflight, f1b_inflight;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  formula_sched #(.FORMULA(2), .IMPL(1), .N_WORKERS(4)) u_dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .a(a), .b(b), .c(c),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .inflight(inflight), .err(err));

  formula_sched #(.FORMULA(1), .IMPL(1), .N_WORKERS(2)) u_f1a (
    .clk(clk), .rst(rst), .arg_vld(f1_vld), .arg_rdy(f1a_arg_rdy), .a(a), .b(b), .c(c),
    .res_vld(f1a_res_vld), .res_rdy(f1_rdy), .res(f1a_res), .inflight(f1a_inflight), .err(f1a_err));

  formula_sched #(.FORMULA(1), .IMPL(2), .N_WORKERS(2)) u_f1b (
    .clk(clk), .rst(rst), .arg_vld(f1_vld), .arg_rdy(f1b_arg_rdy), .a(a), .b(b), .c(c),
    .res_vld(f1b_res_vld), .res_rdy(f1_rdy), .res(f1b_res), .inflight(f1b_inflight), .err(f1b_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_isqrt(input logic [31:0] x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return 32'(r);
  endfunction

  function automatic logic [31:0] ref_f2(input logic [31:0] xa, input logic [31:0] xb,
                                         input logic [31:0] xc);
    return ref_isqrt(xa + ref_isqrt(xb + ref_isqrt(xc)));
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int lat_a, lat_b, got, first_n, last_n, seen;
    logic [31:0] stall_a [4];
    stall_a[0] = 32'd1; stall_a[1] = 32'd6; stall_a[2] = 32'd22; stall_a[3] = 32'd33;

    rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b0; f1_vld = 1'b0; f1_rdy = 1'b0;
    a = '0; b = '0; c = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_arg_rdy", arg_rdy, 1);
    check("rst_res_vld", res_vld, 0);
    check("rst_res", res, 0);
    check("rst_inflight", inflight, 0);
    check("rst_err", err, 0);
    check("rst_f1_rdy", f1a_arg_rdy, 1);

    // Single transaction on both formula-1 flavours: isqrt 4,9,16 -> 2+3+4.
    a = 32'd4; b = 32'd9; c = 32'd16; f1_vld = 1'b1;
    tick();
    f1_vld = 1'b0;
    check("f1_inflight_1", f1a_inflight, 1);
    lat_a = 0; lat_b = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (f1a_res_vld && lat_a == 0) lat_a = n;
      if (f1b_res_vld && lat_b == 0) lat_b = n;
    end
    check("f1i1_latency", lat_a, 18);
    check("f1i2_latency", lat_b, 52);
    check("f1i1_res", f1a_res, 9);
    check("f1i2_res", f1b_res, 9);
    f1_rdy = 1'b1;
    tick();
    f1_rdy = 1'b0;
    check("f1i1_inflight_0", f1a_inflight, 0);
    check("f1i2_inflight_0", f1b_inflight, 0);
    check("f1i1_drained", f1a_res_vld, 0);

    // Back-to-back: four accepts in four cycles, then full.
    res_rdy = 1'b1; arg_vld = 1'b1; b = 32'd5; c = 32'd16;
    for (int i = 0; i < 4; i++) begin
      a = 32'd13 + 32'(i);
      check($sformatf("b2b_rdy%0d", i), arg_rdy, 1);
      tick();
    end
    check("b2b_full", arg_rdy, 0);
    check("b2b_inflight", inflight, 4);
    arg_vld = 1'b0;
    got = 0; first_n = -1; last_n = -1;
    for (int n = 0; n < 200 && got < 4; n++) begin
      if (res_vld) begin
        check("b2b_res", res, 4);
        if (first_n < 0) first_n = n;
        last_n = n;
        got++;
      end
      tick();
    end
    check("b2b_count", got, 4);
    check("b2b_one_per_cycle", last_n - first_n, 3);
    check("b2b_inflight_0", inflight, 0);

    // Downstream stall, then freed-slot timing and ordered drain.
    res_rdy = 1'b0; arg_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = stall_a[i];
      tick();
    end
    arg_vld = 1'b0;
    repeat (60) tick();
    check("stall_res_mid", res, 2);
    repeat (93) tick();
    check("stall_arg_rdy", arg_rdy, 0);
    check("stall_inflight", inflight, 4);
    check("stall_res_vld", res_vld, 1);
    check("stall_res", res, 2);
    res_rdy = 1'b1;
    check("free_no_bypass", arg_rdy, 0);
    tick();
    check("free_rdy_next", arg_rdy, 1);
    check("drain_vld1", res_vld, 1);
    check("drain_res1", res, 3);
    tick();
    check("drain_res2", res, 5);
    tick();
    check("drain_res3", res, 6);
    tick();
    check("drain_empty", res_vld, 0);
    check("drain_inflight", inflight, 0);
    res_rdy = 1'b0;

    // Reset with three slots running.
    arg_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'd100 + 32'(i);
      tick();
    end
    arg_vld = 1'b0;
    repeat (10) tick();
    check("mid_inflight", inflight, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_inflight", inflight, 0);
    check("mrst_arg_rdy", arg_rdy, 1);
    check("mrst_res_vld", res_vld, 0);
    seen = 0;
    repeat (102) begin
      tick();
      if (res_vld) seen++;
    end
    check("mrst_no_stale", seen, 0);
    check("mrst_err", err, 0);

    // Pointer wrap under random stalls on both sides.
    fork
      begin
        for (int i = 0; i < 13; i++) begin
          int waited;
          repeat ($urandom_range(0, 3)) tick();
          a = 32'(i * 7 + 1); b = 32'(i * 13); c = 32'(i * 29 + 5);
          arg_vld = 1'b1;
          waited = 0;
          while (!arg_rdy && waited < 500) begin
            tick();
            waited++;
          end
          check("wrap_accept_rdy", arg_rdy, 1);
          exp_q.push_back(ref_f2(a, b, c));
          tick();
          arg_vld = 1'b0;
        end
      end
      begin
        int wgot, cyc;
        logic [31:0] e;
        wgot = 0; cyc = 0;
        while (wgot < 13 && cyc < 6000) begin
          res_rdy = 1'($urandom_range(0, 1));
          if (res_vld && res_rdy) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check($sformatf("wrap_res%0d", wgot), res, e);
            wgot++;
          end
          tick();
          cyc++;
        end
        res_rdy = 1'b0;
        check("wrap_count", wgot, 13);
      end
    join
    tick();
    check("wrap_inflight_0", inflight, 0);
    check("final_err", err, 0);
    check("final_f1_err", f1a_err | f1b_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/formula_sched.md
# formula_sched

Bounded-resource scheduler for the formula pipelines: accepts (a, b, c) triplets over a valid/ready handshake and dispatches them in strict round-robin to a small pool of FSM-based formula workers (`formula_1_impl_1_top`, `formula_1_impl_2_top` or `formula_2_top`). It buffers each worker's result and returns results in acceptance order over a valid/ready handshake. When every worker is occupied, or when downstream holds results, it deasserts `arg_rdy` and stalls upstream instead of dropping work. It replaces the idealized wide distributor wherever 3–5 workers plus backpressure are sufficient.

## Interface
- `FORMULA`, default 1: formula selector, 1 or 2.
- `IMPL`, default 1: implementation selector for formula 1, 1 or 2; ignored when `FORMULA`=2.
- `N_WORKERS`, default 4: number of worker slots, range 2..8.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high; also drives every worker's `rst`.
- `arg_vld`  in  1  upstream triplet valid.
- `arg_rdy`  out  1  scheduler can accept a triplet this cycle.
- `a`, `b`, `c`  in  32 each  arguments; sampled only on accept.
- `res_vld`  out  1  oldest outstanding result is available.
- `res_rdy`  in  1  downstream consumes the result this cycle.
- `res`  out  32  result data; valid only while `res_vld`=1.
- `inflight`  out  $clog2(N_WORKERS+1)  number of slots not in IDLE.
- `err`  out  1  sticky flag; set on a worker `res_vld` while its slot is not in RUN.

## Operation
- Each slot k has a state `slot_st[k]` in {IDLE, RUN, DONE} and a 32-bit `slot_res[k]`.
- Two pointers, `in_ptr` and `out_ptr`, each range 0..N_WORKERS-1 and wrap N_WORKERS-1 → 0.
- Accept: `arg_rdy` = (`slot_st[in_ptr]`==IDLE). An accept happens when `arg_vld`&&`arg_rdy`.
- On accept:
  - worker `in_ptr` receives a one-cycle `arg_vld` pulse in the accept cycle; `a`/`b`/`c` go combinationally to all workers.
  - `slot_st[in_ptr]` becomes RUN and `in_ptr` increments.
- Worker k `res_vld` while slot k is RUN: `slot_res[k]` ← worker `res` and the slot becomes DONE. In any other state the pulse is ignored and `err` ← 1.
- Output: `res_vld` = (`slot_st[out_ptr]`==DONE) and `res` = `slot_res[out_ptr]`. Both are functions of registers only; there is no combinational path from a worker to `res`.
- Consume: when `res_vld`&&`res_rdy`, `slot_st[out_ptr]` becomes IDLE and `out_ptr` increments.
- `res_vld`/`res` stay stable while `res_rdy`=0.
- Results leave strictly in acceptance order, even if workers finish out of order (data-dependent latency). A finished later slot waits in DONE.
- Simultaneous events:
  - Accept and consume in the same cycle are independent and both happen.
  - A slot freed by a consume becomes acceptable the next cycle; there is no same-cycle bypass.
- Full: every slot is RUN or DONE, so `arg_rdy`=0. Empty: every slot is IDLE, so `res_vld`=0 and `inflight`=0.
- Invariant: `in_ptr`==`out_ptr` only when `inflight` is 0 or N_WORKERS.

## Timing
- Reset values: every slot IDLE, both pointers 0, `slot_res` 0, `err` 0.
- Output values after reset: `arg_rdy`=1, `res_vld`=0, `res`=0, `inflight`=0.
- Reset mid-operation: all in-flight work is discarded. Workers reset on the same edge; no stale result may appear after reset.
- Latency: accept at edge T, worker `res_vld` at T+L (L = worker latency). `res_vld` rises at T+L+1 if the slot is at `out_ptr`; otherwise later.
- Throughput: at most N_WORKERS accepts per L+2 cycles when downstream never stalls.
- `err` clears only on `rst`.

## Structure
- Package `formula_sched_pkg`: `slot_state_t` enum {IDLE, RUN, DONE}; a `ptr_inc` function for modulo-N_WORKERS pointer increment.
- Sub-module `formula_sched_slot`: one slot's state register, result register, `err` contribution and a generate-selected worker instance chosen by `FORMULA`/`IMPL`.
- Top level: pointers, `arg_rdy`/`res_vld` muxes, `inflight` popcount, `err` OR-reduction.

## Test plan
- Single transaction: `FORMULA`=1, a=4, b=9, c=16. Required: `res`=9 with `res_vld` exactly L+1 cycles after accept, `inflight` 1 → 0.
- Back-to-back: `FORMULA`=2, `N_WORKERS`=4, `arg_vld` held high with c=16, b=5, a=13, and `res_rdy`=1. Required:
  - 4 accepts in 4 cycles, then `arg_rdy`=0;
  - each result equals 4;
  - order matches input order (tag by varying a = 13, 14, 15…).
- Downstream stall: `res_rdy`=0 for 3L cycles. Required: all slots DONE, `arg_rdy`=0, `res` stable. Releasing `res_rdy` drains N_WORKERS results in order, one per cycle.
- Freed-slot timing: consume from a full scheduler at edge T. Required: `arg_rdy` rises at T+1, not at T.
- Reset mid-run: assert `rst` with 3 slots RUN. Required:
  - next cycle `inflight`=0, `arg_rdy`=1, `res_vld`=0;
  - no `res_vld` for 2L cycles without new input;
  - `err`=0.
- Pointer wrap: 3×N_WORKERS+1 transactions with random stalls on both sides. Required: every result matches the reference model, in order.
